// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next accepted start.
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dreg_q, dreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dz_q, dz_d;
    logic [WIDTH:0]     trial;

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dreg_d  = dreg_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        // One extra bit so the borrow shows up as the MSB
        trial   = {rem_q, quot_q[WIDTH-1]} - {1'b0, dreg_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    quot_d  = dividend;
                    dreg_d  = divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    dz_d    = (divisor == '0);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dreg_q  <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dreg_q  <= dreg_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider: latency, held results,
// divide-by-zero, ignored restart, async reset mid-run, back-to-back issue.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient, remainder;
    logic        busy, done, div_zero;

    int n_chk = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse start for one cycle, then scramble operands to prove they were captured.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Called on a negedge that is cycle c0 after the accepting edge; returns
    // the cycle on which done was seen (40 on timeout) and busy cycles seen.
    task automatic wait_done(input int c0, output int cyc, output int bsy);
        cyc = c0;
        bsy = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bsy++;
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz);
        int cyc, bsy;
        issue(a, b);
        wait_done(1, cyc, bsy);
        chk("latency", cyc, 17);
        chk("quot", quotient, eq);
        chk("rem", remainder, er);
        chk("dz", div_zero, edz);
    endtask

    initial begin
        int cyc, bsy;
        logic [15:0] a, b;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // 100/7 with busy-window and hold checks
        issue(16'd100, 16'd7);
        wait_done(1, cyc, bsy);
        chk("lat_100_7", cyc, 17);
        chk("busy_cycles", bsy, 16);
        chk("q_100_7", quotient, 14);
        chk("r_100_7", remainder, 2);
        chk("dz_100_7", div_zero, 0);
        repeat (3) @(negedge clk);
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 0);
        chk("hold_q", quotient, 14);
        chk("hold_r", remainder, 2);

        run(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        run(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        run(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        repeat (2) @(negedge clk);
        chk("dz_held", div_zero, 1);
        run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

        // Restart attempt during RUN must be ignored
        issue(16'd100, 16'd7);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(3, cyc, bsy);
        chk("ign_lat", cyc, 17);
        chk("ign_q", quotient, 14);
        chk("ign_r", remainder, 2);

        // Async reset between edges while running
        issue(16'd100, 16'd7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_quot", quotient, 0);
        chk("arst_rem", remainder, 0);
        @(negedge clk);
        rst = 1'b0;
        run(16'd20, 16'd6, 16'd3, 16'd2, 1'b0);

        // start held high: second op accepted in the DONE cycle
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd33;
        start    = 1'b1;
        @(negedge clk);
        wait_done(1, cyc, bsy);
        chk("b2b_lat1", cyc, 17);
        chk("b2b_q1", quotient, 30);
        chk("b2b_r1", remainder, 10);
        dividend = 16'd7;
        divisor  = 16'd2;
        @(negedge clk);
        dividend = 16'd999;
        divisor  = 16'd4;
        wait_done(1, cyc, bsy);
        start = 1'b0;
        chk("b2b_gap", cyc, 17);
        chk("b2b_q2", quotient, 3);
        chk("b2b_r2", remainder, 1);

        // Random sweep against the bench's own integer divide
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            run(a, b, a / b, a % b, 1'b0);
            chk("inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned shift-subtract (restoring) divider, one quotient bit per clock. It is the inverse companion of the shift-add multiplier.
- Controller FSM and datapath live in one module, with a start/busy/done handshake to the surrounding control logic.
- Used by the LFSR/arithmetic path wherever a modulo or quotient of a 16-bit value is needed.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high; forces IDLE and clears all registers
- start  input  1  request; sampled on clk, accepted only in IDLE or DONE
- dividend  input  WIDTH  numerator; captured on the accepted-start edge
- divisor  input  WIDTH  denominator; captured on the accepted-start edge
- quotient  output  WIDTH  registered result; valid while done=1, held until next accepted start
- remainder  output  WIDTH  registered result; same validity as quotient
- busy  output  1  high while RUN
- done  output  1  high exactly one cycle, in DONE state
- div_zero  output  1  registered; divisor==0 at capture; valid with done, held with results

Behaviour:
- Reset (async, any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0.
  - Any operation in flight is discarded.
- States: IDLE, RUN, DONE; registered state, Moore outputs.
- IDLE:
  - start=1 → capture dividend into quotient shift register, divisor into d_reg.
  - remainder←0, counter←WIDTH, div_zero←(divisor==0), go RUN.
  - start=0 → stay; outputs hold their last values.
- RUN, each edge:
  - t = {remainder, quotient[WIDTH-1]} − {1'b0, d_reg}, computed at WIDTH+1 bits.
  - If t is non-negative (MSB=0): remainder←t[WIDTH-1:0], quotient←{quotient[WIDTH-2:0],1}.
  - Otherwise: remainder←{remainder[WIDTH-2:0], quotient[WIDTH-1]}, quotient←{quotient[WIDTH-2:0],0}.
  - counter←counter−1. When counter==1 on this edge (last iteration), go DONE.
- DONE (one cycle): done=1, busy=0.
  - start=1 → accepted exactly as from IDLE, go RUN (back-to-back operation).
  - start=0 → go IDLE.
- start during RUN: ignored; captured operands and results are not affected.
- Latency:
  - Start accepted at edge E0; busy=1 after edges E0..E15; DONE entered at edge E16.
  - done=1 for the cycle following E16. Issue-to-issue 17 cycles when back-to-back.
- Divide by zero:
  - No special-casing of the arithmetic. The algorithm naturally yields quotient=all-ones and remainder=dividend.
  - div_zero=1 flags the condition.
- Arithmetic: unsigned only. The trial subtract uses WIDTH+1 bits so the remainder never overflows. Invariant at done: dividend = quotient·divisor + remainder, with remainder < divisor (divisor≠0).
- Operands may change after the capture edge without effect.

Test Plan:
- 100/7: pulse start → busy for 16 cycles, done one cycle later; quotient=14, remainder=2, div_zero=0, results held after done.
- 16'hFFFF/1 → quotient=16'hFFFF, remainder=0. 16'hFFFF/16'hFFFF → 1 r 0. 3/10 → 0 r 3.
- 5/0 → quotient=16'hFFFF, remainder=5, div_zero=1. A following 9/3 → 3 r 0, div_zero=0.
- start re-pulsed with 50/5 during RUN of 100/7 → ignored; result 14 r 2 at the original done time.
- rst asserted asynchronously mid-RUN (between edges) → busy, done, quotient and remainder go to 0 immediately. A later 20/6 → 3 r 2 with normal latency.
- start held high through DONE → next operation accepted in the DONE cycle; second done appears 17 cycles after the first; random 1000-vector sweep satisfies the divide invariant.
